// File: rtl/ahb_pkg.sv
// Shared AHB definitions: bus widths, HTRANS/HRESP/HSIZE encodings and the
// master interface state enumeration.
package ahb_pkg;

  localparam int AHB_ADDR_BITS = 32;
  localparam int AHB_DATA_BITS = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} state_t;

endpackage

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master: arbitrates for the bus, runs one address/data
// phase pair and retries on RETRY/SPLIT up to MAX_RETRY times.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = AHB_ADDR_BITS,
  parameter int DATA_W    = AHB_DATA_BITS,
  parameter int MAX_RETRY = 15
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_lock,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HBUSREQ,
  output logic              HLOCK,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA
);

  localparam int CNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t              state_reg, state_next;
  logic                write_reg, lock_reg;
  logic [ADDR_W-1:0]   addr_reg, haddr_reg;
  logic [2:0]          size_reg, hsize_reg;
  logic [DATA_W-1:0]   wdata_reg, rdata_reg;
  logic [CNT_W-1:0]    retry_cnt_reg;
  logic                hwrite_reg, valid_reg, err_reg;

  logic accept, grant_take, retry_take, done, done_err;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    HBUSREQ    = 1'b0;
    HLOCK      = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HWDATA     = '0;
    accept     = 1'b0;
    grant_take = 1'b0;
    retry_take = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gated so the port reads 0 while reset is held.
        req_ready = HRESETn;
        if (req_valid && HRESETn) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        HBUSREQ = 1'b1;
        HLOCK   = lock_reg;
        if (HGRANT && HREADY) begin
          grant_take = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        HTRANS  = HTRANS_NONSEQ;
        HBUSREQ = lock_reg;
        HLOCK   = lock_reg;
        if (HREADY) state_next = DATA;
      end
      DATA: begin
        HWDATA  = wdata_reg;
        HBUSREQ = lock_reg;
        HLOCK   = lock_reg;
        if (HREADY) begin
          case (HRESP)
            HRESP_OKAY: done = 1'b1;
            HRESP_ERROR: begin
              done     = 1'b1;
              done_err = 1'b1;
            end
            default: begin
              if (retry_cnt_reg < CNT_W'(MAX_RETRY)) retry_take = 1'b1;
              else begin
                done     = 1'b1;
                done_err = 1'b1;
              end
            end
          endcase
          state_next = retry_take ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      lock_reg      <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      retry_cnt_reg <= '0;
      haddr_reg     <= '0;
      hwrite_reg    <= 1'b0;
      hsize_reg     <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg     <= req_write;
        lock_reg      <= req_lock;
        addr_reg      <= req_addr;
        size_reg      <= req_size;
        wdata_reg     <= req_wdata;
        retry_cnt_reg <= '0;
      end
      if (retry_take) retry_cnt_reg <= retry_cnt_reg + CNT_W'(1);
      // Address-phase controls only change when ownership is taken, so they
      // hold their last values otherwise.
      if (grant_take) begin
        haddr_reg  <= addr_reg;
        hwrite_reg <= write_reg;
        hsize_reg  <= size_reg;
      end
      valid_reg <= done;
      err_reg   <= done_err;
      rdata_reg <= (done && !done_err && !write_reg) ? HRDATA : '0;
    end
  end

  assign HADDR     = haddr_reg;
  assign HWRITE    = hwrite_reg;
  assign HSIZE     = hsize_reg;
  assign rsp_valid = valid_reg;
  assign rsp_err   = err_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: a scripted arbiter/slave per transfer, with
// a scoreboard queue checked by a monitor whenever rsp_valid is seen.
module tb_ahb_master_if;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid, req_write, req_lock;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        HGRANT, HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        HBUSREQ, HLOCK, HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 HCLK = ~HCLK;

  ahb_master_if #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(15)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .HGRANT(HGRANT), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // Scoreboard monitor.
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        $display("rsp: rdata=%h err=%0b (expected %h/%0b)", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
  end

  // kind: 0 = final OKAY, 1 = final ERROR, 2 = the last RETRY ends the request.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input logic lock,
                         input int gdelay, input int hr_low, input int waits,
                         input int nretry, input int kind, input logic [31:0] rdata,
                         input int exp_issues);
    exp_t e;
    int   issues = 0;
    int   left   = nretry;
    int   gd     = gdelay;
    bit   fin    = 0;
    chk({tag, ":req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_wdata = wdata; req_lock = lock;
    tick();
    req_valid = 1'b0;
    e.err   = (kind != 0);
    e.rdata = (kind == 0 && !wr) ? rdata : 32'd0;
    exp_q.push_back(e);
    while (!fin) begin
      for (int i = 0; i < gd; i++) begin
        chk({tag, ":busreq_wait"}, {31'd0, HBUSREQ}, 32'd1);
        chk({tag, ":htrans_wait"}, {30'd0, HTRANS}, 32'd0);
        HGRANT = 1'b0; HREADY = 1'b1; tick();
      end
      gd = 0;
      for (int i = 0; i < hr_low; i++) begin
        chk({tag, ":busreq_hrlow"}, {31'd0, HBUSREQ}, 32'd1);
        chk({tag, ":htrans_hrlow"}, {30'd0, HTRANS}, 32'd0);
        HGRANT = 1'b1; HREADY = 1'b0; tick();
      end
      chk({tag, ":busreq"}, {31'd0, HBUSREQ}, 32'd1);
      chk({tag, ":hlock_req"}, {31'd0, HLOCK}, {31'd0, lock});
      HGRANT = 1'b1; HREADY = 1'b1; tick();
      // Address phase
      chk({tag, ":htrans_addr"}, {30'd0, HTRANS}, 32'h2);
      chk({tag, ":haddr"}, HADDR, addr);
      chk({tag, ":hwrite"}, {31'd0, HWRITE}, {31'd0, wr});
      chk({tag, ":hsize"}, {29'd0, HSIZE}, {29'd0, size});
      chk({tag, ":busreq_addr"}, {31'd0, HBUSREQ}, {31'd0, lock});
      if (HTRANS == 2'b10) issues++;
      HGRANT = 1'b0; HREADY = 1'b1; tick();
      // Data phase
      chk({tag, ":htrans_data"}, {30'd0, HTRANS}, 32'd0);
      chk({tag, ":hwdata"}, HWDATA, wdata);
      for (int w = 0; w < waits; w++) begin
        HREADY = 1'b0; HRESP = 2'b00; tick();
        chk({tag, ":htrans_wait_st"}, {30'd0, HTRANS}, 32'd0);
        chk({tag, ":hwdata_wait_st"}, HWDATA, wdata);
      end
      if (left > 0) begin
        HRESP = (left % 2 == 1) ? 2'b10 : 2'b11; HREADY = 1'b0; tick();
        chk({tag, ":htrans_retry2"}, {30'd0, HTRANS}, 32'd0);
        HREADY = 1'b1; tick();
        HRESP = 2'b00;
        left--;
        if (left == 0 && kind == 2) fin = 1;
      end else if (kind == 1) begin
        HRESP = 2'b01; HREADY = 1'b0; tick();
        chk({tag, ":htrans_err2"}, {30'd0, HTRANS}, 32'd0);
        HREADY = 1'b1; tick();
        HRESP = 2'b00;
        fin = 1;
      end else begin
        HRESP = 2'b00; HREADY = 1'b1; HRDATA = rdata; tick();
        HRDATA = $urandom;
        fin = 1;
      end
    end
    HGRANT = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    chk({tag, ":rsp_latency"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ":issues"}, issues, exp_issues);
    chk({tag, ":hlock_done"}, {31'd0, HLOCK}, 32'd0);
    chk({tag, ":busreq_done"}, {31'd0, HBUSREQ}, 32'd0);
    $display("txn %s: addr=%h wr=%0b issues=%0d", tag, addr, wr, issues);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, ":rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ":rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ":rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, ":hbusreq"}, {31'd0, HBUSREQ}, 32'd0);
    chk({tag, ":hlock"}, {31'd0, HLOCK}, 32'd0);
    chk({tag, ":htrans"}, {30'd0, HTRANS}, 32'd0);
    chk({tag, ":haddr"}, HADDR, 32'd0);
    chk({tag, ":hwrite"}, {31'd0, HWRITE}, 32'd0);
    chk({tag, ":hsize"}, {29'd0, HSIZE}, 32'd0);
    chk({tag, ":hwdata"}, HWDATA, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_lock = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    HGRANT = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    repeat (3) @(negedge HCLK);
    chk_all_zero("reset");
    HRESETn = 1'b1;
    tick();

    run_txn("rd_basic", 1'b0, 32'h0000_1000, 3'd2, 32'h0, 1'b0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
    run_txn("wr_waits", 1'b1, 32'h0000_2004, 3'd2, 32'h1234_5678, 1'b0, 0, 0, 3, 0, 0, 32'h0, 1);
    run_txn("rd_nogrant", 1'b0, 32'h0000_3008, 3'd1, 32'h0, 1'b0, 5, 2, 0, 0, 0, 32'hA5A5_0001, 1);
    run_txn("wr_error", 1'b1, 32'h0000_4000, 3'd0, 32'h0000_00AB, 1'b0, 1, 0, 1, 0, 1, 32'h0, 1);
    run_txn("rd_retry2", 1'b0, 32'h0000_5010, 3'd2, 32'h0, 1'b0, 0, 1, 0, 2, 0, 32'h0BAD_F00D, 3);
    run_txn("rd_lock_r15", 1'b0, 32'h0000_6000, 3'd2, 32'h0, 1'b1, 0, 0, 0, 15, 0, 32'h1357_9BDF, 16);
    run_txn("wr_retry_max", 1'b1, 32'h0000_7000, 3'd2, 32'hCAFE_0000, 1'b0, 0, 0, 0, 16, 2, 32'h0, 16);

    // Reset asserted in the middle of a data phase.
    chk("rst_mid:req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_8000; req_size = 3'd2;
    req_wdata = 32'h5555_AAAA; req_lock = 1'b1;
    tick();
    req_valid = 1'b0;
    HGRANT = 1'b1; HREADY = 1'b1; tick();
    HGRANT = 1'b0; tick();
    chk("rst_mid:hwdata_pre", HWDATA, 32'h5555_AAAA);
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1 chk_all_zero("rst_mid");
    repeat (2) tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    tick();
    run_txn("wr_after_rst", 1'b1, 32'h0000_9000, 3'd1, 32'h0000_BEEF, 1'b0, 0, 0, 1, 0, 0, 32'h0, 1);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
